// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the 5-stage pipeline control logic.
//   REG_W      - register-index width
//   fwd_sel_t  - EX operand mux select codes (RF / MEM / WB / MDU)
package pipe_pkg;
    localparam int REG_W = 5;
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_MDU = 2'b11
    } fwd_sel_t;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: combinational per-source forwarding comparator against EX and MEM producers.
//   in : src, use_src, ex_valid/ex_wen/ex_is_load/ex_rd, mem_valid/mem_wen/mem_rd
//   out: code (select code for the next cycle), load_haz (EX producer is a load)
module fwd_match #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic             ex_valid,
    input  logic             ex_wen,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_valid,
    input  logic             mem_wen,
    input  logic [REG_W-1:0] mem_rd,
    output logic [1:0]       code,
    output logic             load_haz
);
    import pipe_pkg::*;
    logic     q, ex_hit, mem_hit;
    fwd_sel_t sel;
    // r0 is hardwired zero, so it never needs forwarding; EX is the younger producer and wins
    always_comb begin
        q       = use_src & (src != '0);
        ex_hit  = q & ex_valid & ex_wen & (ex_rd == src);
        mem_hit = q & mem_valid & mem_wen & (mem_rd == src);
        sel     = ex_hit ? FWD_MEM : mem_hit ? FWD_WB : FWD_RF;
    end
    assign code     = sel;
    assign load_haz = ex_hit & ex_is_load;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: ID-stage hazard detection and registered EX operand forwarding selects.
//   in : clk, rst (async, active-high), ID source info, EX/MEM producer info, ex_br_taken
//   out: fwd_a_sel/fwd_b_sel (registered), stall_pc, stall_id, flush_id, bubble_ex, mdu_busy
//   HAZARD_MDU_EN enables the MDU busy counter, MDU stall and the MDU select code.
module hazard_fwd_ctrl #(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_use_mdu,
    input  logic             id_mdu_start,
    input  logic             ex_valid,
    input  logic             ex_wen,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_valid,
    input  logic             mem_wen,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             ex_br_taken,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             mdu_busy
);
    import pipe_pkg::*;
    logic       use_mdu, ld_a, ld_b, stall, adv;
    logic [1:0] code_a, code_b;
    // an MDU reader takes its operands from HI/LO, so its GPR source flags are ignored
    fwd_match #(.REG_W(REG_W)) u_a (
        .src(id_rs), .use_src(id_valid & id_use_rs & ~use_mdu),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd),
        .code(code_a), .load_haz(ld_a)
    );
    fwd_match #(.REG_W(REG_W)) u_b (
        .src(id_rt), .use_src(id_valid & id_use_rt & ~use_mdu),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd),
        .code(code_b), .load_haz(ld_b)
    );
`ifdef HAZARD_MDU_EN
    localparam int CW = $clog2(MDU_LAT) + 1;
    logic [CW-1:0] cnt;
    assign use_mdu  = id_valid & id_use_mdu;
    assign mdu_busy = cnt != '0;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (id_valid & id_mdu_start & adv)
            cnt <= CW'(MDU_LAT);
        else if (mdu_busy)
            cnt <= cnt - CW'(1);
`else
    logic unused_mdu;
    assign unused_mdu = id_use_mdu ^ id_mdu_start ^ (MDU_LAT < 2);
    assign use_mdu    = 1'b0;
    assign mdu_busy   = 1'b0;
`endif
    // a taken branch kills the ID instruction, so any stall it would have caused is moot
    assign stall     = (ld_a | ld_b | (use_mdu & mdu_busy)) & ~ex_br_taken;
    assign adv       = ~stall & ~ex_br_taken;
    assign stall_pc  = stall;
    assign stall_id  = stall;
    assign flush_id  = ex_br_taken;
    assign bubble_ex = stall | ex_br_taken;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            fwd_a_sel <= ~adv ? FWD_RF : use_mdu ? FWD_MDU : code_a;
            fwd_b_sel <= ~adv ? FWD_RF : use_mdu ? FWD_MDU : code_b;
        end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed and randomized self-checking bench for hazard_fwd_ctrl.
module tb_hazard_fwd_ctrl;
    localparam int LAT = 8;
`ifdef HAZARD_MDU_EN
    localparam bit MEN = 1'b1;
`else
    localparam bit MEN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_use_rs, id_use_rt, id_use_mdu, id_mdu_start;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic ex_valid, ex_wen, ex_is_load, mem_valid, mem_wen, ex_br_taken;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic stall_pc, stall_id, flush_id, bubble_ex, mdu_busy;

    hazard_fwd_ctrl #(.REG_W(5), .MDU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_mdu(id_use_mdu),
        .id_mdu_start(id_mdu_start), .ex_valid(ex_valid), .ex_wen(ex_wen),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_wen(mem_wen),
        .mem_rd(mem_rd), .ex_br_taken(ex_br_taken), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall_pc(stall_pc), .stall_id(stall_id),
        .flush_id(flush_id), .bubble_ex(bubble_ex), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int start_cyc = -100;
    logic [1:0] m_a = 2'b00;
    logic [1:0] m_b = 2'b00;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    endtask

    // newest producer of s among EX (code 1) then MEM (code 2); r0 and unused sources never forward
    function automatic logic [1:0] mcode(input logic [4:0] s, input logic u);
        if (!u || s == 0) return 2'd0;
        if (ex_valid && ex_wen && ex_rd == s) return 2'd1;
        if (mem_valid && mem_wen && mem_rd == s) return 2'd2;
        return 2'd0;
    endfunction

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_use_mdu = 0; id_mdu_start = 0; ex_valid = 0; ex_wen = 0; ex_is_load = 0;
        ex_rd = 0; mem_valid = 0; mem_wen = 0; mem_rd = 0; ex_br_taken = 0;
    endtask

    task automatic async_rst();
        rst = 1;
        m_a = 0; m_b = 0; start_cyc = -100;
    endtask

    // check every output against the model at the negedge, then advance the model past the posedge
    task automatic tick();
        bit busy, umdu, ld, stl, adv;
        logic [1:0] na, nb;
        int ns;
        @(negedge clk);
        busy = MEN && (cyc - start_cyc) >= 1 && (cyc - start_cyc) <= LAT;
        umdu = MEN && id_valid && id_use_mdu;
        ld = id_valid && !umdu && ex_valid && ex_wen && ex_is_load &&
             ((id_use_rs && id_rs != 0 && ex_rd == id_rs) || (id_use_rt && id_rt != 0 && ex_rd == id_rt));
        stl = !ex_br_taken && id_valid && (ld || (umdu && busy));
        adv = !stl && !ex_br_taken;
        chk("stall_pc", stall_pc, stl);
        chk("stall_id", stall_id, stl);
        chk("flush_id", flush_id, ex_br_taken);
        chk("bubble_ex", bubble_ex, stl || ex_br_taken);
        chk("mdu_busy", mdu_busy, busy);
        chk("fwd_a_sel", fwd_a_sel, m_a);
        chk("fwd_b_sel", fwd_b_sel, m_b);
        na = !adv ? 2'd0 : umdu ? 2'd3 : id_valid ? mcode(id_rs, id_use_rs) : 2'd0;
        nb = !adv ? 2'd0 : umdu ? 2'd3 : id_valid ? mcode(id_rt, id_use_rt) : 2'd0;
        ns = (MEN && adv && id_valid && id_mdu_start) ? cyc : start_cyc;
        @(posedge clk);
        #1;
        if (rst) begin
            m_a = 0; m_b = 0; start_cyc = -100;
        end else begin
            m_a = na; m_b = nb; start_cyc = ns;
        end
        cyc++;
    endtask

    initial begin
        int n;
        idle();
        rst = 1;
        #1;
        tick();
        tick();
        chk("rst_sel_a", fwd_a_sel, 0);
        chk("rst_busy", mdu_busy, 0);
        rst = 0;
        // EX add writes r5, ID reads rs=r5
        idle(); id_valid = 1; id_rs = 5; id_use_rs = 1; ex_valid = 1; ex_wen = 1; ex_rd = 5;
        #1 chk("ex_fwd_nostall", stall_pc, 0);
        tick();
        chk("ex_fwd_a", fwd_a_sel, 2'b01);
        // EX and MEM both write r7, ID reads rt=r7
        idle(); id_valid = 1; id_rt = 7; id_use_rt = 1; ex_valid = 1; ex_wen = 1; ex_rd = 7;
        mem_valid = 1; mem_wen = 1; mem_rd = 7;
        tick();
        chk("ex_priority_b", fwd_b_sel, 2'b01);
        // MEM-only producer
        idle(); id_valid = 1; id_rt = 9; id_use_rt = 1; mem_valid = 1; mem_wen = 1; mem_rd = 9;
        tick();
        chk("mem_fwd_b", fwd_b_sel, 2'b10);
        // load-use on r3: one bubble, then forwarded from WB
        idle(); id_valid = 1; id_rs = 3; id_use_rs = 1; ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_rd = 3;
        #1 chk("lu_stall", stall_pc, 1);
        chk("lu_bubble", bubble_ex, 1);
        tick();
        ex_valid = 0; ex_wen = 0; ex_is_load = 0; mem_valid = 1; mem_wen = 1; mem_rd = 3;
        #1 chk("lu_bubble_sel", fwd_a_sel, 2'b00);
        chk("lu_released", stall_pc, 0);
        tick();
        chk("lu_wb_sel", fwd_a_sel, 2'b10);
        // r0 never forwards
        idle(); id_valid = 1; id_rs = 0; id_use_rs = 1; ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_rd = 0;
        #1 chk("r0_nostall", stall_pc, 0);
        tick();
        chk("r0_sel", fwd_a_sel, 2'b00);
        // div then mfhi: stall until the result is ready
        idle(); id_valid = 1; id_mdu_start = 1;
        tick();
        idle(); id_valid = 1; id_use_mdu = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!stall_pc) break;
            n++;
            tick();
        end
        chk("mdu_stall_len", n, MEN ? LAT : 0);
        tick();
        chk("mdu_sel_a", fwd_a_sel, MEN ? 2'b11 : 2'b00);
        chk("mdu_sel_b", fwd_b_sel, MEN ? 2'b11 : 2'b00);
        // load-use coincident with a taken branch
        idle(); id_valid = 1; id_rs = 3; id_use_rs = 1; ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_rd = 3;
        ex_br_taken = 1;
        #1 chk("br_flush", flush_id, 1);
        chk("br_bubble", bubble_ex, 1);
        chk("br_nostall", stall_pc, 0);
        tick();
        // async reset in the middle of an MDU stall
        idle(); id_valid = 1; id_mdu_start = 1;
        tick();
        idle(); id_valid = 1; id_use_mdu = 1;
        tick();
        tick();
        #2 chk("pre_rst_stall", stall_pc, MEN);
        async_rst();
        #1;
        chk("arst_stall", stall_pc, 0);
        chk("arst_bubble", bubble_ex, 0);
        chk("arst_busy", mdu_busy, 0);
        chk("arst_sel", {fwd_a_sel, fwd_b_sel}, 0);
        tick();
        rst = 0;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_valid = ($urandom_range(0, 7) != 0);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_use_rs = $urandom_range(0, 1) == 1;
            id_use_rt = $urandom_range(0, 1) == 1;
            id_use_mdu = ($urandom_range(0, 3) == 0);
            id_mdu_start = ($urandom_range(0, 15) == 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_wen = $urandom_range(0, 1) == 1;
            ex_is_load = $urandom_range(0, 1) == 1;
            ex_rd = 5'($urandom_range(0, 3));
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_wen = $urandom_range(0, 1) == 1;
            mem_rd = 5'($urandom_range(0, 3));
            ex_br_taken = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) async_rst();
            else rst = 0;
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
